cpu_tick_controller: RTL and testbench

Run/step/halt controller on the divided clock. Samples the divider's Slow_Clock in the Fast_Clock domain, detects its rising edges, and converts them into single-cycle Cpu_Tick enables for the processor core. Ticks pass in free-run mode, one per debounced button press in single-step mode, and never while the processor asserts Halt. Also keeps a retired-tick counter for board display and debug.

---
 rtl/cpu_tick_controller.sv | 136 +++++++++++++
 tb/tb_cpu_tick_controller.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_tick_controller.sv
// cpu_tick_controller: run/step/halt gate that turns Slow_Clock rising edges,
// sampled as data in the Fast_Clock domain, into single-cycle Cpu_Tick enables.
//
// Ports:
//   Fast_Clock   in   sole clock, rising edge
//   Reset        in   synchronous, active-high
//   Slow_Clock   in   divided clock, already registered on Fast_Clock
//   Run_Mode     in   raw slide switch, 1 = free-run, 0 = stopped/step
//   Step_Button  in   raw push button, active-high, bouncy
//   Halt         in   processor halt request (level, unsynchronized)
//   Cpu_Tick     out  registered one-cycle core advance enable
//   Running      out  registered, 1 while in RUN
//   Tick_Count   out  Cpu_Tick pulses issued since reset, wraps silently
module cpu_tick_controller #(
  parameter int unsigned DEBOUNCE_COUNT = 4,
  parameter int unsigned COUNT_WIDTH    = 32
) (
  input  logic                   Fast_Clock,
  input  logic                   Reset,
  input  logic                   Slow_Clock,
  input  logic                   Run_Mode,
  input  logic                   Step_Button,
  input  logic                   Halt,
  output logic                   Cpu_Tick,
  output logic                   Running,
  output logic [COUNT_WIDTH-1:0] Tick_Count
);

  localparam int unsigned DEB_W = (DEBOUNCE_COUNT < 2) ? 1 : $clog2(DEBOUNCE_COUNT + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_COUNT - 1);

  typedef enum logic [1:0] {
    ST_STOP,
    ST_RUN,
    ST_STEP_PEND
  } state_e;

  state_e                 state_q, state_d;
  logic                   run_meta_q, run_sync_q;
  logic                   step_meta_q, step_sync_q;
  logic                   deb_level_q, deb_level_d;
  logic [DEB_W-1:0]       deb_cnt_q, deb_cnt_d;
  logic                   press_q, press_d;
  logic                   slow_q;
  logic                   cpu_tick_q, cpu_tick_d;
  logic                   running_q, running_d;
  logic [COUNT_WIDTH-1:0] tick_count_q, tick_count_d;
  logic                   rise_c;

  // Slow_q resets high so the divider's reset-high level is not seen as an edge
  assign rise_c = Slow_Clock & ~slow_q;

  // Debouncer: level changes only after DEBOUNCE_COUNT consecutive differing samples
  always_comb begin
    deb_level_d = deb_level_q;
    deb_cnt_d   = '0;
    press_d     = 1'b0;
    if (step_sync_q != deb_level_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        deb_level_d = step_sync_q;
        press_d     = step_sync_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
    end
  end

  // Next state and tick issue; Halt overrides every state
  always_comb begin
    state_d    = state_q;
    cpu_tick_d = 1'b0;
    if (Halt) begin
      state_d = ST_STOP;
    end else begin
      unique case (state_q)
        ST_STOP: begin
          if (run_sync_q)   state_d = ST_RUN;
          else if (press_q) state_d = ST_STEP_PEND;
        end
        ST_RUN: begin
          if (!run_sync_q) state_d = ST_STOP;
          else             cpu_tick_d = rise_c;
        end
        ST_STEP_PEND: begin
          if (run_sync_q) begin
            // Switching to free-run absorbs the pending step
            state_d    = ST_RUN;
            cpu_tick_d = rise_c;
          end else if (rise_c) begin
            state_d    = ST_STOP;
            cpu_tick_d = 1'b1;
          end
        end
        default: state_d = ST_STOP;
      endcase
    end
    running_d    = (state_d == ST_RUN);
    tick_count_d = tick_count_q + COUNT_WIDTH'(cpu_tick_d);
  end

  // State registers
  always_ff @(posedge Fast_Clock) begin
    if (Reset) begin
      state_q      <= ST_STOP;
      run_meta_q   <= 1'b0;
      run_sync_q   <= 1'b0;
      step_meta_q  <= 1'b0;
      step_sync_q  <= 1'b0;
      deb_level_q  <= 1'b0;
      deb_cnt_q    <= '0;
      press_q      <= 1'b0;
      slow_q       <= 1'b1;
      cpu_tick_q   <= 1'b0;
      running_q    <= 1'b0;
      tick_count_q <= '0;
    end else begin
      state_q      <= state_d;
      run_meta_q   <= Run_Mode;
      run_sync_q   <= run_meta_q;
      step_meta_q  <= Step_Button;
      step_sync_q  <= step_meta_q;
      deb_level_q  <= deb_level_d;
      deb_cnt_q    <= deb_cnt_d;
      press_q      <= press_d;
      slow_q       <= Slow_Clock;
      cpu_tick_q   <= cpu_tick_d;
      running_q    <= running_d;
      tick_count_q <= tick_count_d;
    end
  end

  assign Cpu_Tick   = cpu_tick_q;
  assign Running    = running_q;
  assign Tick_Count = tick_count_q;

endmodule

// File: tb/tb_cpu_tick_controller.sv
// Testbench for cpu_tick_controller: expected tick cycles are queued when a
// Slow_Clock rise is driven and matched against Cpu_Tick as it appears.
module tb_cpu_tick_controller;

  logic        Fast_Clock = 1'b0;
  logic        Reset, Slow_Clock, Run_Mode, Step_Button, Halt;
  logic        Cpu_Tick, Running;
  logic [31:0] Tick_Count;
  logic        cpu_tick4, running4;
  logic [3:0]  tick_count4;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int exp_q[$];

  cpu_tick_controller #(.DEBOUNCE_COUNT(4), .COUNT_WIDTH(32)) u_dut (
    .Fast_Clock (Fast_Clock),
    .Reset      (Reset),
    .Slow_Clock (Slow_Clock),
    .Run_Mode   (Run_Mode),
    .Step_Button(Step_Button),
    .Halt       (Halt),
    .Cpu_Tick   (Cpu_Tick),
    .Running    (Running),
    .Tick_Count (Tick_Count)
  );

  // Narrow-counter instance sharing all stimulus, used for the wrap check
  cpu_tick_controller #(.DEBOUNCE_COUNT(4), .COUNT_WIDTH(4)) u_dut4 (
    .Fast_Clock (Fast_Clock),
    .Reset      (Reset),
    .Slow_Clock (Slow_Clock),
    .Run_Mode   (Run_Mode),
    .Step_Button(Step_Button),
    .Halt       (Halt),
    .Cpu_Tick   (cpu_tick4),
    .Running    (running4),
    .Tick_Count (tick_count4)
  );

  always #5 Fast_Clock = ~Fast_Clock;

  always @(posedge Fast_Clock) cyc <= cyc + 1;

  // Scoreboard: every observed tick must match the oldest expected cycle
  always @(negedge Fast_Clock) begin
    if (exp_q.size() > 0 && exp_q[0] < cyc) begin
      checks++;
      errors++;
      $display("FAIL missed_tick: no Cpu_Tick at cycle %0d, required one", exp_q[0]);
      void'(exp_q.pop_front());
    end
    if (Cpu_Tick === 1'b1) begin
      checks++;
      if (exp_q.size() == 0 || exp_q[0] != cyc) begin
        errors++;
        $display("FAIL unexpected_tick: Cpu_Tick=1 at cycle %0d, expected cycle %0d",
                 cyc, (exp_q.size() > 0) ? exp_q[0] : -1);
      end else begin
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic clk_step();
    @(posedge Fast_Clock);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) clk_step();
  endtask

  // One Slow_Clock period: 6 cycles low, then rise and 6 cycles high
  task automatic slow_period(input bit expect_tick);
    Slow_Clock = 1'b0;
    steps(6);
    Slow_Clock = 1'b1;
    if (expect_tick) exp_q.push_back(cyc + 1);
    steps(6);
  endtask

  task automatic test_reset();
    Reset = 1'b1; Slow_Clock = 1'b1; Run_Mode = 1'b0; Step_Button = 1'b0; Halt = 1'b0;
    steps(2);
    checks++;
    if (Cpu_Tick !== 1'b0 || Running !== 1'b0 || Tick_Count !== 32'd0 || tick_count4 !== 4'd0) begin
      errors++;
      $display("FAIL reset_values: tick=%b running=%b count=%0d count4=%0d, required 0/0/0/0",
               Cpu_Tick, Running, Tick_Count, tick_count4);
    end
    Reset = 1'b0;
  endtask

  task automatic test_run_no_edges();
    Run_Mode = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      clk_step();
      checks++;
      if (Running !== (i >= 3)) begin
        errors++;
        $display("FAIL run_latency: cycle %0d Running=%b required %b", i, Running, i >= 3);
      end
    end
    checks++;
    if (Tick_Count !== 32'd0) begin
      errors++;
      $display("FAIL run_no_edges_count: Tick_Count=%0d required 0", Tick_Count);
    end
  endtask

  task automatic test_free_run();
    logic [31:0] start = Tick_Count;
    for (int p = 0; p < 10; p++) slow_period(1'b1);
    checks++;
    if (Tick_Count !== start + 32'd10 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL free_run_count: Tick_Count=%0d pending=%0d required %0d pending=0",
               Tick_Count, exp_q.size(), start + 32'd10);
    end
  endtask

  task automatic test_step();
    logic [31:0] start;
    Run_Mode = 1'b0;
    steps(3);
    checks++;
    if (Running !== 1'b0) begin
      errors++;
      $display("FAIL step_stop: Running=%b required 0", Running);
    end
    slow_period(1'b0);
    start = Tick_Count;
    // Bouncy press: 1/0/1 then held
    Step_Button = 1'b1; clk_step();
    Step_Button = 1'b0; clk_step();
    Step_Button = 1'b1; clk_step();
    steps(10);
    Step_Button = 1'b0;
    steps(10);
    checks++;
    if (Running !== 1'b0 || Cpu_Tick !== 1'b0) begin
      errors++;
      $display("FAIL step_pending: Running=%b tick=%b required 0/0", Running, Cpu_Tick);
    end
    // Second press while pending must be dropped
    Step_Button = 1'b1; steps(10);
    Step_Button = 1'b0; steps(10);
    slow_period(1'b1);
    slow_period(1'b0);
    checks++;
    if (Tick_Count !== start + 32'd1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL step_count: Tick_Count=%0d required %0d", Tick_Count, start + 32'd1);
    end
  endtask

  task automatic test_halt();
    logic [31:0] start;
    Run_Mode = 1'b1;
    steps(3);
    checks++;
    if (Running !== 1'b1) begin
      errors++;
      $display("FAIL halt_pre_run: Running=%b required 1", Running);
    end
    start = Tick_Count;
    Slow_Clock = 1'b0;
    steps(6);
    Slow_Clock = 1'b1;
    Halt = 1'b1;
    clk_step();
    checks++;
    if (Running !== 1'b0 || Cpu_Tick !== 1'b0) begin
      errors++;
      $display("FAIL halt_on_rise: Running=%b tick=%b required 0/0", Running, Cpu_Tick);
    end
    steps(4);
    Halt = 1'b0;
    clk_step();
    checks++;
    if (Running !== 1'b1) begin
      errors++;
      $display("FAIL halt_release: Running=%b required 1", Running);
    end
    slow_period(1'b1);
    slow_period(1'b1);
    checks++;
    if (Tick_Count !== start + 32'd2) begin
      errors++;
      $display("FAIL halt_resume_count: Tick_Count=%0d required %0d", Tick_Count, start + 32'd2);
    end
  endtask

  task automatic test_wrap();
    Reset = 1'b1; clk_step(); Reset = 1'b0;
    steps(3);
    checks++;
    if (Running !== 1'b1 || tick_count4 !== 4'd0) begin
      errors++;
      $display("FAIL wrap_start: Running=%b count4=%0d required 1/0", Running, tick_count4);
    end
    for (int k = 1; k <= 17; k++) begin
      slow_period(1'b1);
      if (k >= 15) begin
        checks++;
        if (tick_count4 !== 4'(k) || Tick_Count !== 32'(k)) begin
          errors++;
          $display("FAIL wrap_tick%0d: count4=%0d count=%0d required %0d/%0d",
                   k, tick_count4, Tick_Count, 4'(k), k);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    Slow_Clock = 1'b0;
    steps(6);
    Slow_Clock = 1'b1;
    Reset = 1'b1;
    clk_step();
    Reset = 1'b0;
    checks++;
    if (Cpu_Tick !== 1'b0 || Tick_Count !== 32'd0 || Running !== 1'b0 || tick_count4 !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid: tick=%b count=%0d running=%b count4=%0d required 0/0/0/0",
               Cpu_Tick, Tick_Count, Running, tick_count4);
    end
    steps(2);
    checks++;
    if (Running !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_stop: Running=%b required 0", Running);
    end
    clk_step();
    checks++;
    if (Running !== 1'b1 || Tick_Count !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_rerun: Running=%b count=%0d required 1/0", Running, Tick_Count);
    end
  endtask

  initial begin
    test_reset();
    test_run_no_edges();
    test_free_run();
    test_step();
    test_halt();
    test_wrap();
    test_reset_mid();
    steps(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_ticks: %0d expected ticks never seen, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
